// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int WORDS_DEF  = 64;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-input round-robin pick; the pointer lives in the caller.
module rr_arbiter2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic prio_i,
    output logic winner_o,
    output logic any_o
);

    always_comb begin
        any_o    = req0_i | req1_i;
        winner_o = 1'b0;
        if (req0_i && req1_i) begin
            winner_o = prio_i;
        end else if (req1_i) begin
            winner_o = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer sharing one data-memory port: IDLE -> ACCESS -> DONE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WORDS  = WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state_o,
    output logic              dbg_prio_o
);

    arb_state_e        state_q, state_d;
    logic              prio_q, prio_d;
    port_id_t          id_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              pick;
    logic              any_req;
    logic              latch_en;
    logic              in_range;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req0_i   (req0),
        .req1_i   (req1),
        .prio_i   (prio_q),
        .winner_o (pick),
        .any_o    (any_req)
    );

    assign in_range  = (addr_q < DATA_W'(WORDS));
    assign sel_we    = pick ? we1    : we0;
    assign sel_addr  = pick ? addr1  : addr0;
    assign sel_wdata = pick ? wdata1 : wdata0;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    latch_en = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                prio_d  = ~id_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (latch_en) begin
                id_q    <= pick;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            // Read data is sampled at the edge closing ACCESS; writes and bad addresses yield 0.
            if (state_q == ACCESS) begin
                rdata_q <= (!we_q && in_range) ? mem_rdata : '0;
                err_q   <= !in_range;
            end
        end
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        err0      = 1'b0;
        err1      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ACCESS) begin
            gnt0      = (id_q == 1'b0);
            gnt1      = (id_q == 1'b1);
            mem_we    = in_range && we_q;
            mem_re    = in_range && !we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end else if (state_q == DONE) begin
            if (id_q == 1'b0) begin
                done0  = 1'b1;
                rdata0 = rdata_q;
                err0   = err_q;
            end else begin
                done1  = 1'b1;
                rdata1 = rdata_q;
                err1   = err_q;
            end
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_prio_o  = prio_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word memory model behind the memory port.
module tb_dmem_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [DW-1:0] addr0, addr1, wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]    dbg_state;
    logic          dbg_prio;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [64];

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .WORDS(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .err0        (err0),
        .err1        (err1),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .dbg_state_o (dbg_state),
        .dbg_prio_o  (dbg_prio)
    );

    // Memory decodes only the low 6 address bits, so a stray write to 64 would alias word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[5:0]];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [DW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One uncontended access starting from IDLE: gnt next cycle, done the cycle after.
    task automatic access(input int p, input logic w, input logic [DW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                          input logic exp_err, input string tag);
        logic ok;
        ok = (a < 64);
        drive(p, 1'b1, w, a, d);
        @(negedge clk);
        chk($sformatf("%s.gnt", tag), (p == 0) ? gnt0 : gnt1, 1);
        chk($sformatf("%s.gnt_other", tag), (p == 0) ? gnt1 : gnt0, 0);
        chk($sformatf("%s.mem_we", tag), mem_we, w & ok);
        chk($sformatf("%s.mem_re", tag), mem_re, !w & ok);
        chk($sformatf("%s.mem_addr", tag), mem_addr, a);
        drive(p, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk($sformatf("%s.done", tag), (p == 0) ? done0 : done1, 1);
        chk($sformatf("%s.done_other", tag), (p == 0) ? done1 : done0, 0);
        chk($sformatf("%s.rdata", tag), (p == 0) ? rdata0 : rdata1, exp_rd);
        chk($sformatf("%s.err", tag), (p == 0) ? err0 : err1, exp_err);
        chk($sformatf("%s.mem_idle", tag), {mem_we, mem_re, mem_addr != 0}, 0);
        @(negedge clk);
        chk($sformatf("%s.back_idle", tag), {dbg_state, done0, done1}, 0);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid_q[$];
        int gcyc_q[$];
        int did_q[$];
        int dcyc_q[$];
        int overlap;
        int exp_id[4];
        int exp_gc[4];

        // Reset then idle
        do_reset();
        @(negedge clk);
        chk("rst.gnt", {gnt0, gnt1}, 0);
        chk("rst.done", {done0, done1}, 0);
        chk("rst.rdata", rdata0 | rdata1, 0);
        chk("rst.err", {err0, err1}, 0);
        chk("rst.mem_ctl", {mem_we, mem_re}, 0);
        chk("rst.mem_bus", mem_addr | mem_wdata, 0);
        chk("rst.state", dbg_state, 0);
        chk("rst.prio", dbg_prio, 0);

        // Single write then read on port 0
        access(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, "wr5");
        access(0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, "rd5");

        // Contention from reset: grants at cycles 1,4,7,10 alternating 0,1,0,1
        do_reset();
        drive(0, 1'b1, 1'b0, 32'd1, '0);
        drive(1, 1'b1, 1'b0, 32'd2, '0);
        overlap = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) overlap++;
            if (gnt0) begin gid_q.push_back(0); gcyc_q.push_back(c); end
            if (gnt1) begin gid_q.push_back(1); gcyc_q.push_back(c); end
            if (done0) begin did_q.push_back(0); dcyc_q.push_back(c); end
            if (done1) begin did_q.push_back(1); dcyc_q.push_back(c); end
            if (gid_q.size() >= 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        exp_id = '{0, 1, 0, 1};
        exp_gc = '{1, 4, 7, 10};
        chk("cont.overlap", overlap, 0);
        chk("cont.ngnt", gid_q.size(), 4);
        chk("cont.ndone", did_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont.gid%0d", i), (i < gid_q.size()) ? gid_q[i] : -1, exp_id[i]);
            chk($sformatf("cont.gcyc%0d", i), (i < gcyc_q.size()) ? gcyc_q[i] : -1, exp_gc[i]);
            chk($sformatf("cont.did%0d", i), (i < did_q.size()) ? did_q[i] : -1, exp_id[i]);
            chk($sformatf("cont.dcyc%0d", i), (i < dcyc_q.size()) ? dcyc_q[i] : -1, exp_gc[i] + 1);
        end
        chk("cont.prio", dbg_prio, 0);

        // Out-of-range on port 1, and word 0 must not be aliased
        access(1, 1'b1, 32'd64, 32'h1234, 32'h0, 1'b1, "oor_wr");
        access(1, 1'b0, 32'd64, 32'h0, 32'h0, 1'b1, "oor_rd");
        access(1, 1'b0, 32'd0, 32'h0, 32'h0, 1'b0, "rd0");

        // Cross-port coherence at the top word
        access(1, 1'b1, 32'd63, 32'hA5A5A5A5, 32'h0, 1'b0, "x_wr63");
        access(0, 1'b0, 32'd63, 32'h0, 32'hA5A5A5A5, 1'b0, "x_rd63");
        chk("pre_abort.prio", dbg_prio, 1);

        // Reset during ACCESS of a port 0 read
        drive(0, 1'b1, 1'b0, 32'd63, '0);
        @(negedge clk);
        chk("abort.gnt_before", gnt0, 1);
        reset = 1'b1;
        req0  = 1'b0;
        #1;
        chk("abort.gnt", {gnt0, gnt1}, 0);
        chk("abort.mem", {mem_we, mem_re, mem_addr != 0}, 0);
        chk("abort.state", dbg_state, 0);
        chk("abort.prio", dbg_prio, 0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort.no_done", {done0, done1}, 0);
        chk("abort.rdata", rdata0 | rdata1, 0);
        chk("abort.idle", dbg_state, 0);
        drive(0, 1'b1, 1'b0, 32'd3, '0);
        drive(1, 1'b1, 1'b0, 32'd4, '0);
        @(negedge clk);
        chk("post.gnt0", gnt0, 1);
        chk("post.gnt1", gnt1, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk("post.done0", done0, 1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
